// File: rtl/lm32_dp_ram_clr.sv
// lm32_dp_ram_clr
// Simple dual-port RAM with one byte-enabled write port and one registered read
// port. After reset an internal sweep writes clear_value to every word so that
// tag/TLB arrays start out invalid. User accesses are ignored while it runs.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset, restarts the clear sweep
//   we_i         write request
//   be_i         byte-lane enables, bit n covers wdata_i[8n+7:8n]
//   waddr_i      write address
//   wdata_i      write data
//   re_i         read enable; rdata_o holds while low
//   raddr_i      read address
//   rdata_o      registered read data (clear_value after reset)
//   init_busy_o  high while the clear sweep runs
module lm32_dp_ram_clr #(
   parameter int                    addr_width  = 10,
   parameter int                    addr_depth  = 1024,
   parameter int                    data_width  = 32,
   parameter logic [data_width-1:0] clear_value = '0,
   parameter bit                    bypass      = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      we_i,
   input  logic [data_width/8-1:0]   be_i,
   input  logic [addr_width-1:0]     waddr_i,
   input  logic [data_width-1:0]     wdata_i,
   input  logic                      re_i,
   input  logic [addr_width-1:0]     raddr_i,
   output logic [data_width-1:0]     rdata_o,
   output logic                      init_busy_o
);

   localparam int                  NB    = data_width / 8;
   localparam logic [addr_width:0] LIM   = (addr_width+1)'(addr_depth);
   localparam logic [addr_width-1:0] LAST = addr_width'(addr_depth - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                  r_state, w_state_nxt;
   logic [addr_width-1:0]   r_cnt, w_cnt_nxt;
   logic [data_width-1:0]   r_mem [0:addr_depth-1];
   logic [data_width-1:0]   r_rdata;
   logic [data_width-1:0]   w_rd_word;
   logic                    w_ready;
   logic                    w_wr_in, w_rd_in;
   logic                    w_wr_ok;

   assign w_ready     = (r_state == S_READY);
   // Extend by one bit so a full-depth RAM (depth == 2^addr_width) compares correctly.
   assign w_wr_in     = ({1'b0, waddr_i} < LIM);
   assign w_rd_in     = ({1'b0, raddr_i} < LIM);
   assign w_wr_ok     = w_ready & we_i & w_wr_in;
   assign init_busy_o = (r_state == S_CLEAR);
   assign rdata_o     = r_rdata;

   // Sweep FSM: state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Sweep FSM: next state. The counter parks on the last address once done.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (r_state == S_CLEAR) begin
         if (r_cnt == LAST) w_state_nxt = S_READY;
         else               w_cnt_nxt   = r_cnt + 1'b1;
      end
   end

   // Storage: sweep writes own the array while clearing; nothing is written in a reset cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= clear_value;
         end else if (w_wr_ok) begin
            for (int n = 0; n < NB; n++)
               if (be_i[n]) r_mem[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
         end
      end
   end

   // Read word with optional write-first forwarding of the enabled lanes.
   always_comb begin
      w_rd_word = r_mem[raddr_i];
      if (bypass && w_wr_ok && (waddr_i == raddr_i)) begin
         for (int n = 0; n < NB; n++)
            if (be_i[n]) w_rd_word[8*n +: 8] = wdata_i[8*n +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rdata <= clear_value;
      end else if (w_ready && re_i) begin
         r_rdata <= w_rd_in ? w_rd_word : clear_value;
      end
   end

endmodule

// File: tb/tb_lm32_dp_ram_clr.sv
// Bench for lm32_dp_ram_clr. Three instances share one stimulus stream:
//   A: depth 16, write-first;  B: depth 16, read-first;  C: depth 12, write-first.
// All use clear_value 0xA5A5A5A5. Reads push expected words into a scoreboard
// queue which is popped and compared one edge later.
module tb_lm32_dp_ram_clr;

   localparam logic [31:0] CLR = 32'hA5A5A5A5;

   logic        clk = 1'b0;
   logic        rst, we, re;
   logic [3:0]  be, waddr, raddr;
   logic [31:0] wdata;
   logic [31:0] rdata_a, rdata_b, rdata_c;
   logic        busy_a, busy_b, busy_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lm32_dp_ram_clr #(.addr_width(4), .addr_depth(16), .data_width(32),
                     .clear_value(CLR), .bypass(1'b1)) u_a (
      .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
      .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(rdata_a),
      .init_busy_o(busy_a));

   lm32_dp_ram_clr #(.addr_width(4), .addr_depth(16), .data_width(32),
                     .clear_value(CLR), .bypass(1'b0)) u_b (
      .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
      .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b),
      .init_busy_o(busy_b));

   lm32_dp_ram_clr #(.addr_width(4), .addr_depth(12), .data_width(32),
                     .clear_value(CLR), .bypass(1'b1)) u_c (
      .clk_i(clk), .rst_i(rst), .we_i(we), .be_i(be), .waddr_i(waddr),
      .wdata_i(wdata), .re_i(re), .raddr_i(raddr), .rdata_o(rdata_c),
      .init_busy_o(busy_c));

   typedef struct {
      bit          we;
      logic [3:0]  be;
      logic [3:0]  wa;
      logic [31:0] wd;
      bit          re;
      logic [3:0]  ra;
      bit          chk;
      logic [31:0] ea, eb, ec;
   } vec_t;

   typedef struct {
      logic [31:0] a, b, c;
   } exp_t;

   vec_t tbl[$];
   exp_t sbq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(bit w, logic [3:0] b, logic [3:0] wa, logic [31:0] wd,
                               bit r, logic [3:0] ra, bit c,
                               logic [31:0] ea, logic [31:0] eb, logic [31:0] ec);
      vec_t v;
      v.we = w; v.be = b; v.wa = wa; v.wd = wd; v.re = r; v.ra = ra;
      v.chk = c; v.ea = ea; v.eb = eb; v.ec = ec;
      return v;
   endfunction

   task automatic apply(input string nm, input vec_t v);
      exp_t e;
      we = v.we; be = v.be; waddr = v.wa; wdata = v.wd; re = v.re; raddr = v.ra;
      if (v.chk) sbq.push_back('{v.ea, v.eb, v.ec});
      tick();
      if (v.chk) begin
         e = sbq.pop_front();
         chk({nm, "_a"}, rdata_a, e.a);
         chk({nm, "_b"}, rdata_b, e.b);
         chk({nm, "_c"}, rdata_c, e.c);
      end
      we = 1'b0; re = 1'b0;
   endtask

   // Release reset and record the edge (counted from 1) after which each busy falls.
   // With poke set, user writes/reads to addr 0 are driven during the sweep.
   task automatic sweep(input bit poke, output int fa, output int fb, output int fc);
      fa = 0; fb = 0; fc = 0;
      rst = 1'b0;
      for (int n = 1; n <= 64; n++) begin
         if (poke && n >= 2 && n <= 10) begin
            we = 1'b1; be = 4'hF; waddr = 4'd0; wdata = 32'hFFFF_FFFF;
            re = 1'b1; raddr = 4'd0;
         end else begin
            we = 1'b0; re = 1'b0;
         end
         tick();
         if (!busy_a && fa == 0) fa = n;
         if (!busy_b && fb == 0) fb = n;
         if (!busy_c && fc == 0) fc = n;
         if (fa != 0 && fb != 0 && fc != 0) break;
      end
      we = 1'b0; re = 1'b0;
   endtask

   function automatic logic [31:0] final_val(int a);
      case (a)
         2:       return 32'h1234_5678;
         5:       return 32'h11BB_33DD;
         7:       return 32'h0000_BEEF;
         8, 9, 10, 11: return 32'h0800_0000 | 32'(a);
         default: return CLR;
      endcase
   endfunction

   initial begin
      int fa, fb, fc;
      rst = 1'b1; we = 1'b0; re = 1'b0; be = '0; waddr = '0; raddr = '0; wdata = '0;
      repeat (3) tick();

      chk("rst_busy_a", 32'(busy_a), 32'd1);
      chk("rst_busy_c", 32'(busy_c), 32'd1);
      chk("rst_rdata_a", rdata_a, CLR);
      chk("rst_rdata_c", rdata_c, CLR);

      sweep(1'b1, fa, fb, fc);
      chk("sweep_len_a", 32'(fa), 32'd16);
      chk("sweep_len_b", 32'(fb), 32'd16);
      chk("sweep_len_c", 32'(fc), 32'd12);
      chk("clear_hold_a", rdata_a, CLR);
      chk("clear_hold_c", rdata_c, CLR);

      // Post-sweep contents; addr 0 also proves the writes during the sweep were dropped.
      for (int a = 0; a < 16; a++)
         tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'(a), 1, CLR, CLR, CLR));
      // Byte enables
      tbl.push_back(mk(1, 4'hF, 4'd5, 32'h1122_3344, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h5, 4'd5, 32'hAABB_CCDD, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd5, 1, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD));
      // Same-address collision
      tbl.push_back(mk(1, 4'hF, 4'd7, 32'h0, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 4'h3, 4'd7, 32'hDEAD_BEEF, 1, 4'd7, 1, 32'h0000_BEEF, 32'h0000_0000, 32'h0000_BEEF));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd7, 1, 32'h0000_BEEF, 32'h0000_BEEF, 32'h0000_BEEF));
      // Read hold while writing elsewhere (raddr points at a word being changed)
      tbl.push_back(mk(1, 4'hF, 4'd2, 32'h1234_5678, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd2, 1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(1, 4'hF, 4'(8 + i), 32'h0800_0000 | 32'(8 + i), 0, 4'd9, 1,
                          32'h1234_5678, 32'h1234_5678, 32'h1234_5678));
      // Out of range for C only
      tbl.push_back(mk(1, 4'hF, 4'd13, 32'hCAFE_F00D, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd13, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, CLR));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd12, 1, 32'h0800_000C, 32'h0800_000C, CLR));
      for (int a = 0; a < 12; a++)
         tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'(a), 1, final_val(a), final_val(a), final_val(a)));
      // Setup for reset-mid-sweep
      tbl.push_back(mk(1, 4'hF, 4'd3, 32'h3333_3333, 0, 4'd0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd3, 1, 32'h3333_3333, 32'h3333_3333, 32'h3333_3333));

      foreach (tbl[i]) apply($sformatf("vec%0d", i), tbl[i]);

      // Reset, run 8 sweep edges, then reset again on sweep edge 9.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (8) tick();
      chk("mid_busy_a", 32'(busy_a), 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_busy_a", 32'(busy_a), 32'd1);
      chk("mid_rst_rdata_b", rdata_b, CLR);
      sweep(1'b0, fa, fb, fc);
      chk("resweep_len_a", 32'(fa), 32'd16);
      chk("resweep_len_b", 32'(fb), 32'd16);
      chk("resweep_len_c", 32'(fc), 32'd12);
      apply("post_rst_a3", mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd3, 1, CLR, CLR, CLR));
      apply("post_rst_a5", mk(0, 4'h0, 4'd0, 32'h0, 1, 4'd5, 1, CLR, CLR, CLR));

      chk("sbq_empty", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/lm32_dp_ram_clr.md
# lm32_dp_ram_clr

Parametrised simple-dual-port RAM: one write port with byte enables, one read port with registered output. It is the next-generation replacement for the plain LM32 dual-port RAM in cache tag/data and TLB arrays. It adds self-clearing on reset via an internal sweep FSM, a read enable with output hold, and configurable read-during-write behaviour, so that MMU/TLB invalidation no longer depends on simulator `initial` blocks.

## Interface

Parameters:
- `addr_width`, 10: width of both address buses.
- `addr_depth`, 1024: number of words. Must be ≤ 2^`addr_width` and ≥ 2.
- `data_width`, 32: word width. Must be a multiple of 8.
- `clear_value`, 0: word written to every location during the reset sweep. Also the reset value of `rdata_o`.
- `bypass`, 1: selects read-during-write behaviour to the same address. 1 = write-first (forward new bytes); 0 = read-first (old data).

Ports:
- `clk_i`, input, 1: single clock; all state is updated on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high. Starts the clear sweep.
- `we_i`, input, 1: write request.
- `be_i`, input, `data_width/8`: byte-lane enables. Bit n covers `wdata_i[8n+7:8n]`.
- `waddr_i`, input, `addr_width`: write address.
- `wdata_i`, input, `data_width`: write data.
- `re_i`, input, 1: read enable.
- `raddr_i`, input, `addr_width`: read address.
- `rdata_o`, output, `data_width`: registered read data.
- `init_busy_o`, output, 1: high while the clear sweep is in progress. The RAM ignores user accesses while this is high.

## Operation

- **FSM states:** CLEAR and READY.
  - `rst_i`=1 → state CLEAR, sweep counter = 0, `rdata_o` = `clear_value`. Holds while `rst_i` is high; no RAM write occurs in a reset cycle.
  - CLEAR with `rst_i`=0: writes `clear_value` to `ram[counter]`, then increments the counter. When `counter == addr_depth-1` is written, the next state is READY.
  - READY: remains there until `rst_i`.
- **`init_busy_o`:** = (state == CLEAR). It is registered state, not a combinational decode of `rst_i`.
- **Write (READY only):** on `we_i`=1, for each n with `be_i[n]`=1, byte n of `ram[waddr_i]` ← byte n of `wdata_i`. Lanes with `be_i[n]`=0 are unchanged.
- **Read (READY only):** on `re_i`=1, `rdata_o` ← `ram[raddr_i]` at the next edge. On `re_i`=0, `rdata_o` holds its value.
- **Same-address collision** (`we_i`=`re_i`=1, `waddr_i`==`raddr_i`, READY):
  - `bypass`=1: lanes with `be_i` set return `wdata_i` bytes; other lanes return stored bytes.
  - `bypass`=0: all lanes return pre-write contents.
  - The RAM is updated in both cases.
- **Out-of-range address** (≥ `addr_depth`): write is dropped; read loads `clear_value`.
- **During CLEAR:** `we_i` and `re_i` are ignored. `rdata_o` holds its value (`clear_value` after reset).
- **Reset mid-sweep or during READY:** the sweep restarts from address 0. All contents are treated as lost.

## Timing

- Reset values: `rdata_o` = `clear_value`, `init_busy_o` = 1.
- Sweep length is exactly `addr_depth` cycles after the first edge with `rst_i`=0. `init_busy_o` falls after edge number `addr_depth` (counted from 1).
- The first user write or read is accepted on the first edge where `init_busy_o` is sampled 0.
- Read latency is 1 cycle: address and `re_i` sampled at edge k, data valid after edge k.
- A write at edge k is visible to a read sampled at edge k+1. The same-edge case follows `bypass`.
- The sweep counter is `addr_width` bits wide and never wraps past `addr_depth-1`.

## Test plan

1. **Reset sweep:** depth=16, `clear_value`=0xA5A5A5A5. Pulse `rst_i` for 3 cycles, then count cycles. → `init_busy_o` is high for exactly 16 cycles after deassert. Reading all 16 addresses then returns 0xA5A5A5A5, one cycle after each `re_i`.
2. **Byte enables:** write 0x11223344 to addr 5 with `be_i`=4'b1111. Then write 0xAABBCCDD with `be_i`=4'b0101. Read addr 5. → `rdata_o` = 0x11BB33DD.
3. **Collision:** addr 7 holds 0x00000000. Write 0xDEADBEEF to addr 7 with `be_i`=4'b0011 while reading addr 7 on the same edge.
   - `bypass`=1 → 0x0000BEEF.
   - `bypass`=0 → 0x00000000.
   - A following read returns 0x0000BEEF in both builds.
4. **Read hold and busy gating:** read addr 2 (value X), then hold `re_i`=0 for 5 cycles while writing to other addresses. → `rdata_o` stays X. Assert `we_i`/`re_i` during CLEAR. → no RAM change, and `rdata_o` stays `clear_value`.
5. **Reset mid-sweep:** assert `rst_i` on sweep cycle 9 of 16, after writing addr 3 in READY earlier. → the sweep restarts and `init_busy_o` is high for 16 more cycles. Addr 3 then reads `clear_value`.
6. **Out-of-range:** depth=12, `addr_width`=4. Write addr 13, then read addr 13. → `rdata_o` = `clear_value`, and addresses 0–11 are unaltered.
